// File: rtl/write_buffer_pkg.sv
// Shared definitions for the store write buffer: bus widths, drain FSM encoding
// and the word-granular address compare used by the associative lookup.
package write_buffer_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } wb_state_e;

  // Loads and stores are compared at 32-bit word granularity.
  function automatic logic word_match(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
    return (a[ADDR_W-1:2] == b[ADDR_W-1:2]);
  endfunction

endpackage

// File: rtl/write_buffer_wb_match.sv
// Associative lookup over the pending store entries; when several entries
// match, the one written most recently (nearest the write pointer) wins.
module write_buffer_wb_match
  import write_buffer_pkg::*;
#(
  parameter int WRITE_BUFFER_SIZE = 16,
  localparam int PW = $clog2(WRITE_BUFFER_SIZE)
) (
  input  logic [ADDR_W-1:0]            i_addr [WRITE_BUFFER_SIZE],
  input  logic [DATA_W-1:0]            i_data [WRITE_BUFFER_SIZE],
  input  logic [WRITE_BUFFER_SIZE-1:0] i_valid,
  input  logic [PW-1:0]                i_wr_ptr,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  output logic                         o_hit,
  output logic [DATA_W-1:0]            o_data
);

  logic [PW-1:0] idx_s;

  // Walk from oldest to newest age so the newest match overwrites older ones.
  always_comb begin
    o_hit  = 1'b0;
    o_data = {DATA_W{1'b0}};
    idx_s  = {PW{1'b0}};
    for (int k = WRITE_BUFFER_SIZE; k >= 1; k--) begin
      idx_s = i_wr_ptr - PW'(k);
      if (i_valid[idx_s] && word_match(i_addr[idx_s], i_rd_addr)) begin
        o_hit  = 1'b1;
        o_data = i_data[idx_s];
      end else begin
        o_hit  = o_hit;
        o_data = o_data;
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Store write buffer: a register-based circular FIFO of {addr, data} drained
// one entry at a time to RAM, with store-to-load forwarding for pending entries.
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int WRITE_BUFFER_SIZE = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_hit,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_ram_req,
  input  logic              i_ram_gnt,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_we,
  input  logic              i_ram_wait
);

  localparam int PW = $clog2(WRITE_BUFFER_SIZE);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(WRITE_BUFFER_SIZE);
  localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] COUNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE    = {{(PW-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0]            addr_q [WRITE_BUFFER_SIZE];
  logic [ADDR_W-1:0]            addr_d [WRITE_BUFFER_SIZE];
  logic [DATA_W-1:0]            data_q [WRITE_BUFFER_SIZE];
  logic [DATA_W-1:0]            data_d [WRITE_BUFFER_SIZE];
  logic [WRITE_BUFFER_SIZE-1:0] valid_q, valid_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;

  wb_state_e                    state_q, state_d;
  logic                         ram_req_q, ram_req_d;
  logic [ADDR_W-1:0]            ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]            ram_data_q, ram_data_d;
  logic                         full_q, full_d;
  logic                         empty_q, empty_d;

  logic                         push_s;
  logic                         pop_s;
  logic [PW-1:0]                rd_next_s;

  assign push_s    = i_wr_en && !full_q;
  assign pop_s     = (state_q == ST_WAIT) && !i_ram_wait;
  assign rd_next_s = rd_ptr_q + PTR_ONE;

  // FIFO storage, pointers and occupancy.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_s) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_next_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      addr_d[wr_ptr_q]  = i_wr_addr;
      data_d[wr_ptr_q]  = i_wr_data;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    count_d = count_q + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
  end

  // Drain sequencing; RAM address/data are captured from the head on REQ entry
  // and then held, since the head cannot change until it is popped.
  always_comb begin
    state_d    = state_q;
    ram_req_d  = ram_req_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != COUNT_ZERO) begin
          state_d    = ST_REQ;
          ram_req_d  = 1'b1;
          ram_addr_d = addr_q[rd_ptr_q];
          ram_data_d = data_q[rd_ptr_q];
        end else begin
          state_d   = ST_IDLE;
          ram_req_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (i_ram_gnt) begin
          state_d   = ST_WAIT;
          ram_req_d = 1'b0;
        end else begin
          state_d   = ST_REQ;
          ram_req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!i_ram_wait && (count_q > COUNT_ONE)) begin
          state_d    = ST_REQ;
          ram_req_d  = 1'b1;
          ram_addr_d = addr_q[rd_next_s];
          ram_data_d = data_q[rd_next_s];
        end else if (!i_ram_wait) begin
          state_d   = ST_IDLE;
          ram_req_d = 1'b0;
        end else begin
          state_d   = ST_WAIT;
          ram_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        ram_req_d = 1'b0;
      end
    endcase
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == COUNT_ZERO) && (state_d == ST_IDLE);
  end

  // All state registers; reset abandons any in-flight RAM write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < WRITE_BUFFER_SIZE; i++) begin
        addr_q[i] <= {ADDR_W{1'b0}};
        data_q[i] <= {DATA_W{1'b0}};
      end
      valid_q    <= {WRITE_BUFFER_SIZE{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= COUNT_ZERO;
      state_q    <= ST_IDLE;
      ram_req_q  <= 1'b0;
      ram_addr_q <= {ADDR_W{1'b0}};
      ram_data_q <= {DATA_W{1'b0}};
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      ram_req_q  <= ram_req_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  write_buffer_wb_match #(
    .WRITE_BUFFER_SIZE(WRITE_BUFFER_SIZE)
  ) u_match (
    .i_addr    (addr_q),
    .i_data    (data_q),
    .i_valid   (valid_q),
    .i_wr_ptr  (wr_ptr_q),
    .i_rd_addr (i_rd_addr),
    .o_hit     (o_rd_hit),
    .o_data    (o_rd_data)
  );

  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_ram_req  = ram_req_q;
  assign o_ram_we   = ram_req_q;
  assign o_ram_addr = ram_addr_q;
  assign o_ram_data = ram_data_q;

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: a queue of pending stores is the reference;
// a negedge monitor checks flags, forwarding and every RAM write against it.
module tb_write_buffer;

  localparam int SIZE = 16;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wr_en = 1'b0;
  logic [31:0] i_wr_addr = 32'd0;
  logic [31:0] i_wr_data = 32'd0;
  logic        o_full, o_empty;
  logic [31:0] i_rd_addr = 32'd0;
  logic        o_rd_hit;
  logic [31:0] o_rd_data;
  logic        o_ram_req;
  logic        i_ram_gnt = 1'b0;
  logic [31:0] o_ram_addr, o_ram_data;
  logic        o_ram_we;
  logic        i_ram_wait = 1'b0;

  always #5 clk = ~clk;

  write_buffer #(.WRITE_BUFFER_SIZE(SIZE)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .o_full(o_full), .o_empty(o_empty), .i_rd_addr(i_rd_addr),
    .o_rd_hit(o_rd_hit), .o_rd_data(o_rd_data), .o_ram_req(o_ram_req),
    .i_ram_gnt(i_ram_gnt), .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data),
    .o_ram_we(o_ram_we), .i_ram_wait(i_ram_wait)
  );

  // Reference: stores accepted but not yet retired, oldest first.
  logic [31:0] m_addr[$];
  logic [31:0] m_data[$];
  bit          inflight   = 1'b0;
  bit          armed      = 1'b0;
  bit          after_rst  = 1'b0;
  int          n_cmp      = 0;
  int          n_bad      = 0;
  int          n_writes   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare current outputs, then advance the reference by the coming edge.
  initial begin
    logic        mhit;
    logic [31:0] mdata;
    bit          do_pop, do_push;
    forever begin
      @(negedge clk);
      if (armed) begin
        mhit  = 1'b0;
        mdata = 32'd0;
        foreach (m_addr[k]) begin
          if (m_addr[k][31:2] == i_rd_addr[31:2]) begin
            mhit  = 1'b1;
            mdata = m_data[k];
          end
        end
        check("full", {31'd0, o_full}, {31'd0, m_addr.size() == SIZE});
        check("empty", {31'd0, o_empty}, {31'd0, m_addr.size() == 0});
        check("rd_hit", {31'd0, o_rd_hit}, {31'd0, mhit});
        check("rd_data", o_rd_data, mdata);
        check("ram_we", {31'd0, o_ram_we}, {31'd0, o_ram_req});
        if (m_addr.size() == 0 || inflight)
          check("ram_req_quiet", {31'd0, o_ram_req}, 32'd0);
        if (after_rst) begin
          check("rst_ram_addr", o_ram_addr, 32'd0);
          check("rst_ram_data", o_ram_data, 32'd0);
        end
      end
      if (i_reset) begin
        m_addr.delete();
        m_data.delete();
        inflight  = 1'b0;
        armed     = 1'b1;
        after_rst = 1'b1;
      end else if (armed) begin
        do_pop  = inflight && !i_ram_wait;
        do_push = i_wr_en && (m_addr.size() < SIZE);
        if (o_ram_req && i_ram_gnt && m_addr.size() != 0 && !inflight) begin
          check("ram_addr", o_ram_addr, m_addr[0]);
          check("ram_data", o_ram_data, m_data[0]);
          n_writes++;
          inflight = 1'b1;
        end
        if (do_pop) begin
          void'(m_addr.pop_front());
          void'(m_data.pop_front());
          inflight = 1'b0;
        end
        if (do_push) begin
          m_addr.push_back(i_wr_addr);
          m_data.push_back(i_wr_data);
          after_rst = 1'b0;
        end
      end
    end
  end

  task automatic drive(input bit rst, input bit we, input logic [31:0] wa,
                       input logic [31:0] wd, input bit gnt, input bit wt,
                       input logic [31:0] ra);
    @(posedge clk);
    #2;
    i_reset    = rst;
    i_wr_en    = we;
    i_wr_addr  = wa;
    i_wr_data  = wd;
    i_ram_gnt  = gnt;
    i_ram_wait = wt;
    i_rd_addr  = ra;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 4) == 0)
      return 32'h0000_3000 + 32'($urandom_range(0, 255));
    return 32'h0000_1000 + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while ((m_addr.size() != 0 || inflight) && n < budget) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr());
      n++;
    end
    if (m_addr.size() != 0 || inflight) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", m_addr.size());
    end
  endtask

  int pw_tab[6]  = '{80, 30, 95, 50, 60, 20};
  int pg_tab[6]  = '{20, 90, 10, 60, 100, 50};
  int pwt_tab[6] = '{30, 10, 60, 0, 50, 80};

  initial begin
    int writes_before, budget;
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_1000);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_1000);

    // Single store: grant on the REQ cycle, two wait cycles, then retire.
    drive(1'b0, 1'b1, 32'h0000_0100, 32'hAAAA_0001, 1'b0, 1'b0, 32'h0000_0100);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0100);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0000_0100);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_0100);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_0100);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0100);
    drain(50);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0100);

    // Fill with grant held off; the 17th push must be dropped.
    writes_before = n_writes;
    for (int i = 0; i < SIZE + 1; i++)
      drive(1'b0, 1'b1, 32'h0000_2000 + 32'(i) * 32'd4, 32'hB000_0000 + 32'(i), 1'b0, 1'b0,
            32'h0000_2000 + 32'($urandom_range(0, 16)) * 32'd4);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_2040);
    drain(400);
    check("drained_count", 32'(n_writes - writes_before), 32'd16);

    // Newest-match forwarding and a miss.
    drive(1'b0, 1'b1, 32'h0000_0200, 32'd1, 1'b0, 1'b0, 32'h0000_0202);
    drive(1'b0, 1'b1, 32'h0000_0204, 32'd2, 1'b0, 1'b0, 32'h0000_0202);
    drive(1'b0, 1'b1, 32'h0000_0200, 32'd3, 1'b0, 1'b0, 32'h0000_0202);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0202);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0300);
    drain(100);

    // Full buffer with pushes continuing while it drains.
    for (int i = 0; i < SIZE; i++)
      drive(1'b0, 1'b1, rand_addr(), $urandom(), 1'b0, 1'b0, rand_addr());
    for (int i = 0; i < 80; i++)
      drive(1'b0, 1'b1, rand_addr(), $urandom(), 1'b1, 1'($urandom_range(0, 1)), rand_addr());
    drain(400);

    // Reset while a write is in flight.
    drive(1'b0, 1'b1, 32'h0000_0400, 32'hC0DE_0001, 1'b0, 1'b1, 32'h0000_0400);
    drive(1'b0, 1'b1, 32'h0000_0404, 32'hC0DE_0002, 1'b0, 1'b1, 32'h0000_0400);
    budget = 0;
    while (!inflight && budget < 50) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0000_0400);
      budget++;
    end
    if (!inflight) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_timeout: inflight 0 expected 1");
    end
    drive(1'b1, 1'b1, 32'h0000_0408, 32'hC0DE_0003, 1'b0, 1'b1, 32'h0000_0400);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_0400);
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0404);

    // Randomized traffic in segments of differing push/grant/wait pressure.
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 400; c++)
        drive(1'($urandom_range(0, 599) == 0),
              1'($urandom_range(0, 99) < pw_tab[seg]), rand_addr(), $urandom(),
              1'($urandom_range(0, 99) < pg_tab[seg]),
              1'($urandom_range(0, 99) < pwt_tab[seg]), rand_addr());
    end
    drain(4000);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter WRITE_BUFFER_SIZE, default 16, entry count (power of two, >=2).
REQ-002 i_clk  in  1  ZAP clock; single clock domain.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_wr_en  in  1  push request from cache store path.
REQ-005 i_wr_addr  in  32  store byte address.
REQ-006 i_wr_data  in  32  store data.
REQ-007 o_full  out  1  buffer full; cache stalls stores.
REQ-008 o_empty  out  1  no entries pending, no RAM write in flight.
REQ-009 i_rd_addr  in  32  load address for associative lookup.
REQ-010 o_rd_hit  out  1  combinational: pending entry matches i_rd_addr.
REQ-011 o_rd_data  out  32  combinational: data of newest matching entry; 0 when no hit.
REQ-012 o_ram_req  out  1  request RAM access.
REQ-013 i_ram_gnt  in  1  RAM access granted.
REQ-014 o_ram_addr  out  32  RAM write address.
REQ-015 o_ram_data  out  32  RAM write data.
REQ-016 o_ram_we  out  1  write strobe; high with o_ram_req.
REQ-017 i_ram_wait  in  1  RAM write in progress.

Function
REQ-018 Storage: circular FIFO, WRITE_BUFFER_SIZE entries of {addr, data}; wr/rd pointers wrap modulo size; count width clog2(size)+1.
REQ-019 Push: on rising edge with i_wr_en=1 and o_full=0, entry written at wr pointer; push with o_full=1 ignored (no state change).
REQ-020 o_full = (count == WRITE_BUFFER_SIZE); pop and push in same cycle when not full leaves count unchanged.
REQ-021 Drain FSM states IDLE, REQ, WAIT.
REQ-022 IDLE: count>0 -> REQ next cycle; else stay.
REQ-023 REQ: o_ram_req=1, o_ram_we=1, o_ram_addr/o_ram_data = head entry; i_ram_gnt=1 -> WAIT.
REQ-024 WAIT: o_ram_req=0, address/data held stable; first cycle with i_ram_wait=0 -> head popped, go REQ if count-1>0 else IDLE.
REQ-025 Head entry immutable from REQ entry until pop.
REQ-026 Single write in flight max; minimum 3 cycles per drained entry (REQ, WAIT, back).
REQ-027 Lookup: word compare addr[31:2] over all valid entries including head in flight; multiple hits -> entry nearest wr pointer (newest) wins.
REQ-028 Push of matching address same cycle as lookup not forwarded (lookup sees pre-edge contents).
REQ-029 o_empty = (count == 0) and state == IDLE.

Reset
REQ-030 On i_reset=1 at clock edge: count=0, pointers=0, state=IDLE, all entries invalid.
REQ-031 Reset values: o_full=0, o_empty=1, o_rd_hit=0, o_rd_data=0, o_ram_req=0, o_ram_we=0, o_ram_addr=0, o_ram_data=0.
REQ-032 Reset mid-transaction (REQ or WAIT): in-flight entry discarded, o_ram_req low from next cycle; pending i_ram_wait ignored.
REQ-033 Push coincident with reset ignored.

Structure
REQ-034 Shared package holds FSM state encoding (IDLE/REQ/WAIT) and 32-bit address/data width constants, shared with mmucache.
REQ-035 One sub-module natural: wb_match (associative compare + newest-hit priority select), parameterised by WRITE_BUFFER_SIZE.
REQ-036 Storage in registers (needed for parallel compare); no RAM macro.

Verification
REQ-037 Reset, push (0x100,0xAAAA_0001) -> o_empty=0; gnt=1 next REQ cycle, wait=1 two cycles then 0 -> RAM sees addr 0x100 data 0xAAAA_0001, o_empty=1.
REQ-038 Hold i_ram_gnt=0, push 16 entries -> o_full=1 after 16th; 17th push ignored; drain -> 16 writes, order preserved, no 17th.
REQ-039 Push (0x200,1),(0x204,2),(0x200,3), lookup 0x202 -> o_rd_hit=1, o_rd_data=3; lookup 0x300 -> hit=0, data=0.
REQ-040 Full buffer, push and pop same cycle -> push ignored (full at edge), count=15 after.
REQ-041 Count=1, push and pop same cycle -> count stays 1, pointers wrap correctly across index 15->0.
REQ-042 Assert i_reset during WAIT -> next cycle o_ram_req=0, o_empty=1; later i_ram_wait=0 causes no pop or underflow.
